// File: rtl/mux_pkg.sv
// Shared constants for the dual 2:1 selector block.
package mux_pkg;

  // Default data width of every selector data path
  localparam int unsigned WIDTH_DEFAULT = 1;

endpackage : mux_pkg

// File: rtl/mux2to1_dual_ifelse.sv
// If/else-style 2:1 multiplexer; an unknown select falls through to in0.
module mux_ifelse
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] out,
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1
);

  // Select by if/else; anything other than a clean 1 picks in0
  always_comb begin
    out = in0;
    if (sel) begin
      out = in1;
    end else begin
      out = in0;
    end
  end

endmodule : mux_ifelse

// File: rtl/mux2to1_dual_switch.sv
// Case-style 2:1 multiplexer; an unknown select yields all-zeros.
module mux_switch
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  output logic [WIDTH-1:0] out,
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1
);

  // Select by case; the default arm catches X/Z selects
  always_comb begin
    out = '0;
    case (sel)
      1'b0:    out = in0;
      1'b1:    out = in1;
      default: out = '0;
    endcase
  end

endmodule : mux_switch

// File: rtl/mux2to1_dual.sv
// Dual-channel 2:1 selector: combinational results plus enable-gated,
// asynchronously cleared registered copies for each channel.
module mux2to1_dual
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel_a,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             sel_b,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] y_a,
  output logic [WIDTH-1:0] y_b,
  output logic [WIDTH-1:0] y_a_q,
  output logic [WIDTH-1:0] y_b_q
);

  logic [WIDTH-1:0] y_a_d;
  logic [WIDTH-1:0] y_b_d;

  // Channel A: case-style selector
  mux_switch #(.WIDTH(WIDTH)) u_mux_a (
    .out (y_a),
    .sel (sel_a),
    .in0 (a0),
    .in1 (a1)
  );

  // Channel B: if/else-style selector
  mux_ifelse #(.WIDTH(WIDTH)) u_mux_b (
    .out (y_b),
    .sel (sel_b),
    .in0 (b0),
    .in1 (b1)
  );

  // Next register values: load the live selection when enabled, else hold
  always_comb begin
    y_a_d = y_a_q;
    y_b_d = y_b_q;
    if (en) begin
      y_a_d = y_a;
      y_b_d = y_b;
    end
  end

  // Output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_a_q <= '0;
      y_b_q <= '0;
    end else begin
      y_a_q <= y_a_d;
      y_b_q <= y_b_d;
    end
  end

endmodule : mux2to1_dual

// File: tb/tb_mux2to1_dual.sv
// Self-checking bench for mux2to1_dual at WIDTH=8.
module tb_mux2to1_dual;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         sel_a;
  logic [W-1:0] a0;
  logic [W-1:0] a1;
  logic         sel_b;
  logic [W-1:0] b0;
  logic [W-1:0] b1;
  logic [W-1:0] y_a;
  logic [W-1:0] y_b;
  logic [W-1:0] y_a_q;
  logic [W-1:0] y_b_q;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic         sa;
    logic [W-1:0] da0;
    logic [W-1:0] da1;
    logic         sb;
    logic [W-1:0] db0;
    logic [W-1:0] db1;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  mux2to1_dual #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sel_a (sel_a),
    .a0    (a0),
    .a1    (a1),
    .sel_b (sel_b),
    .b0    (b0),
    .b1    (b1),
    .y_a   (y_a),
    .y_b   (y_b),
    .y_a_q (y_a_q),
    .y_b_q (y_b_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference selection rule from the datasheet: pick d1 when sel is 1, else d0
  function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] d0, input logic [W-1:0] d1);
    return (s == 1'b1) ? d1 : d0;
  endfunction

  initial begin
    logic [W-1:0] mq_a;
    logic [W-1:0] mq_b;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         rs;
    logic [W-1:0] r0;
    logic [W-1:0] r1;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    en    = 1'b1;
    sel_a = 1'b0;
    sel_b = 1'b0;
    a0 = '1; a1 = '1; b0 = '1; b1 = '1;

    // Reset held with enable high and all-ones data
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_yaq", y_a_q, 8'h00);
      chk("rst_ybq", y_b_q, 8'h00);
      chk("rst_ya",  y_a,   8'hFF);
      chk("rst_yb",  y_b,   8'hFF);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_pre_yaq", y_a_q, 8'h00);
    @(negedge clk);
    chk("rel_yaq", y_a_q, 8'hFF);
    chk("rel_ybq", y_b_q, 8'hFF);

    // Select sweep with single-bit data patterns
    sel_a = 1'b0; a0 = 8'h01; a1 = 8'h00;
    sel_b = 1'b0; b0 = 8'h01; b1 = 8'h00;
    #1;
    chk("sw_ya_s0", y_a, 8'h01);
    chk("sw_yb_s0", y_b, 8'h01);
    sel_a = 1'b1; sel_b = 1'b1;
    #1;
    chk("sw_ya_s1", y_a, 8'h00);
    chk("sw_yb_s1", y_b, 8'h00);

    // Table of combinational vectors
    vecs[0] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h56, 8'h78, 8'h12, 8'h56};
    vecs[1] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h56, 8'h78, 8'h34, 8'h78};
    vecs[2] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[4] = '{1'b0, 8'hAA, 8'h55, 1'b0, 8'h55, 8'hAA, 8'hAA, 8'h55};
    vecs[5] = '{1'b1, 8'hAA, 8'h55, 1'b1, 8'h55, 8'hAA, 8'h55, 8'hAA};
    vecs[6] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h80, 8'h01, 8'h01, 8'h80};
    vecs[7] = '{1'b0, 8'h7E, 8'hC3, 1'b1, 8'h3C, 8'hE7, 8'h7E, 8'hE7};
    for (int i = 0; i < 8; i++) begin
      sel_a = vecs[i].sa; a0 = vecs[i].da0; a1 = vecs[i].da1;
      sel_b = vecs[i].sb; b0 = vecs[i].db0; b1 = vecs[i].db1;
      #1;
      chk("tbl_ya", y_a, vecs[i].exp_a);
      chk("tbl_yb", y_b, vecs[i].exp_b);
    end

    // Toggle sweep: one data input toggles every 5 ns, selects invert every 25 ns
    sel_a = 1'b0; sel_b = 1'b1;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    for (int s = 0; s < 60; s++) begin
      case (s % 4)
        0: a0 = ~a0;
        1: a1 = ~a1;
        2: b0 = ~b0;
        default: b1 = ~b1;
      endcase
      if (s != 0 && (s % 5) == 0) begin
        sel_a = ~sel_a;
        sel_b = ~sel_b;
      end
      #1;
      chk("tog_ya", y_a, pick(sel_a, a0, a1));
      chk("tog_yb", y_b, pick(sel_b, b0, b1));
      #4;
    end

    // Enable hold
    @(negedge clk);
    en = 1'b1; sel_a = 1'b0; a0 = 8'hA5;
    @(negedge clk);
    chk("hold_load", y_a_q, 8'hA5);
    en = 1'b0; a0 = 8'h3C;
    repeat (2) @(negedge clk);
    chk("hold_q", y_a_q, 8'hA5);
    chk("hold_ya", y_a, 8'h3C);

    // Asynchronous reset away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_yaq", y_a_q, 8'h00);
    chk("arst_ybq", y_b_q, 8'h00);
    chk("arst_ya",  y_a,   8'h3C);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized equivalence against the reference model
    mq_a = '0;
    mq_b = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rs = 1'($urandom);
      r0 = W'($urandom);
      r1 = W'($urandom);
      en = (i == 0) ? 1'b1 : 1'($urandom);
      sel_a = rs; a0 = r0; a1 = r1;
      sel_b = rs; b0 = r0; b1 = r1;
      ea = pick(rs, r0, r1);
      eb = ea;
      #1;
      chk("rnd_ya", y_a, ea);
      chk("rnd_yb", y_b, eb);
      chk("eq_comb", y_a, y_b);
      @(posedge clk);
      if (en) begin
        mq_a = ea;
        mq_b = eb;
      end
      @(negedge clk);
      chk("rnd_yaq", y_a_q, mq_a);
      chk("eq_reg", y_a_q, y_b_q);
      chk("rnd_ybq", y_b_q, mq_b);
    end

    // Unknown select, only meaningful where the simulator keeps X
    a0 = 8'h01; b0 = 8'h01; a1 = 8'h00; b1 = 8'h00;
    sel_a = 1'bx; sel_b = 1'bx;
    #1;
    if (sel_a === 1'bx) begin
      chk("xsel_ya", y_a, 8'h00);
      chk("xsel_yb", y_b, 8'h01);
    end else begin
      $display("note: two-state simulator, unknown-select check not applicable");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux2to1_dual
